// File: rtl/life_hud_if.sv
// Pixel/ROM bus between the raster scan, the sprite ROM and the lives HUD.
// The HUD is the slave: it receives the pixel position and ROM data and returns pixel results.
interface life_hud_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [3:0]  sprite_data;
  logic [18:0] sprite_addr;
  logic        is_life;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;

  modport master (
    output DrawX, DrawY, sprite_data,
    input  sprite_addr, is_life, Red, Green, Blue
  );

  modport slave (
    input  DrawX, DrawY, sprite_data,
    output sprite_addr, is_life, Red, Green, Blue
  );
endinterface

// File: rtl/life_hud.sv
// Lives HUD: life counter with hit/blink/game-over FSM and a row of icons drawn from a sprite ROM.
// Optional coin bonus (extra life every BONUS_THRESHOLD coins) enabled by LIFE_HUD_BONUS_EN.
module life_hud #(
  parameter int unsigned MAX_LIVES       = 5,
  parameter int unsigned START_LIVES     = 3,
  parameter int unsigned ICON_W          = 15,
  parameter int unsigned ICON_H          = 14,
  parameter int unsigned X_ORIGIN        = 0,
  parameter int unsigned Y_ORIGIN        = 20,
  parameter int unsigned X_PITCH         = 15,
  parameter int unsigned SPRITE_STRIDE   = 188,
  parameter int unsigned BLINK_FRAMES    = 60,
  parameter int unsigned BLINK_HALF      = 4,
  parameter int unsigned BONUS_THRESHOLD = 100
) (
  input  logic             frame_clk,
  input  logic             Reset,
  life_hud_if.slave        pix,
  input  logic             lose_life,
  input  logic             gain_life,
  input  logic             restart,
  input  logic             coin_pulse,
  output logic [3:0]       life_count,
  output logic             invulnerable,
  output logic             game_over
);

  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned HalfW  = $clog2(BLINK_HALF + 1);

  localparam logic [3:0]        MaxLives   = 4'(MAX_LIVES);
  localparam logic [3:0]        StartLives = 4'(START_LIVES);
  localparam logic [BlinkW-1:0] BlinkInit  = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [HalfW-1:0]  HalfLast   = HalfW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {StAlive, StHit, StOver} state_e;

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [BlinkW-1:0] blink_q, blink_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic              phase_q, phase_d;
  logic [3:0]        count_inc;
  logic              gain_eff;

`ifdef LIFE_HUD_BONUS_EN
  localparam int unsigned CoinW = $clog2(BONUS_THRESHOLD + 1);
  localparam logic [CoinW-1:0] CoinLast = CoinW'(BONUS_THRESHOLD - 1);

  logic [CoinW-1:0] coin_q, coin_d;
  logic             bonus;

  always_comb begin
    coin_d = coin_q;
    bonus  = 1'b0;
    if (state_q == StOver) begin
      if (restart) coin_d = '0;
    end else if (coin_pulse) begin
      if (coin_q == CoinLast) begin
        coin_d = '0;
        bonus  = 1'b1;
      end else begin
        coin_d = coin_q + 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) coin_q <= '0;
    else       coin_q <= coin_d;
  end

  assign gain_eff = gain_life | bonus;
`else
  logic unused_coin;
  assign unused_coin = coin_pulse;
  assign gain_eff    = gain_life;
`endif

  assign count_inc  = (count_q >= MaxLives) ? MaxLives : count_q + 4'd1;
  assign life_count = count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    blink_d = blink_q;
    half_d  = half_q;
    phase_d = phase_q;
    unique case (state_q)
      StAlive: begin
        if (lose_life && !gain_eff) begin
          count_d = count_q - 4'd1;
          blink_d = BlinkInit;
          half_d  = '0;
          phase_d = 1'b0;
          state_d = StHit;
        end else if (gain_eff && !lose_life) begin
          count_d = count_inc;
        end
      end
      StHit: begin
        if (gain_eff) count_d = count_inc;
        if (blink_q == '0) begin
          phase_d = 1'b1;
          half_d  = '0;
          state_d = (count_d == 4'd0) ? StOver : StAlive;
        end else begin
          blink_d = blink_q - 1'b1;
          // half_q counts frames within the current on/off phase
          if (half_q == HalfLast) begin
            half_d  = '0;
            phase_d = ~phase_q;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end
      StOver: begin
        if (restart) begin
          count_d = StartLives;
          state_d = StAlive;
        end
      end
      default: state_d = StAlive;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StAlive;
      count_q      <= StartLives;
      blink_q      <= '0;
      half_q       <= '0;
      phase_q      <= 1'b1;
      invulnerable <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      blink_q      <= blink_d;
      half_q       <= half_d;
      phase_q      <= phase_d;
      invulnerable <= (state_q == StHit);
      game_over    <= (state_q == StOver);
    end
  end

  int unsigned px, py, sx;
  logic        in_slot;
  logic [18:0] addr;
  logic [23:0] rgb;

  always_comb begin
    px      = {22'd0, pix.DrawX};
    py      = {22'd0, pix.DrawY};
    sx      = 0;
    in_slot = 1'b0;
    addr    = '0;
    for (int unsigned i = 0; i < MAX_LIVES; i++) begin
      sx = X_ORIGIN + i * X_PITCH;
      // The icon of the life just lost blinks while in HIT
      if ((px >= sx) && (px < sx + ICON_W) && (py >= Y_ORIGIN) && (py < Y_ORIGIN + ICON_H) &&
          ((i < {28'd0, count_q}) ||
           ((i == {28'd0, count_q}) && (state_q == StHit) && phase_q))) begin
        in_slot = 1'b1;
        addr    = 19'((px - sx) + (py - Y_ORIGIN) * SPRITE_STRIDE);
      end
    end
  end

  assign pix.sprite_addr = addr;
  assign pix.is_life     = in_slot && (pix.sprite_data != 4'd0);

  always_comb begin
    rgb = 24'h000000;
    if (pix.is_life) begin
      unique case (pix.sprite_data)
        4'd1:    rgb = 24'hFFFDFB;
        4'd2:    rgb = 24'hB53121;
        4'd3:    rgb = 24'hF83800;
        4'd4:    rgb = 24'hE18300;
        4'd5:    rgb = 24'h1D7B01;
        4'd6:    rgb = 24'hAC7C00;
        4'd7:    rgb = 24'hD4E7C7;
        4'd8:    rgb = 24'h057987;
        4'd9:    rgb = 24'h000000;
        default: rgb = 24'hFF0000;
      endcase
    end
  end

  assign pix.Red   = rgb[23:16];
  assign pix.Green = rgb[15:8];
  assign pix.Blue  = rgb[7:0];

endmodule

// File: tb/tb_life_hud.sv
// Directed bench for life_hud: a vector table for the ALIVE-state pixel/count behaviour plus
// hand-written blink, reset, game-over and coin sequences.
module tb_life_hud;

  logic       frame_clk;
  logic       Reset;
  logic       lose_life, gain_life, restart, coin_pulse;
  logic [3:0] life_count;
  logic       invulnerable, game_over;

  life_hud_if hud_bus ();

  life_hud dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .pix          (hud_bus),
    .lose_life    (lose_life),
    .gain_life    (gain_life),
    .restart      (restart),
    .coin_pulse   (coin_pulse),
    .life_count   (life_count),
    .invulnerable (invulnerable),
    .game_over    (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        lose;
    logic        gain;
    logic        rst_req;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  sd;
    logic [3:0]  cnt;
    logic        inv;
    logic        ovr;
    logic        isl;
    logic [18:0] addr;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y, input logic [3:0] sd);
    hud_bus.DrawX       = x;
    hud_bus.DrawY       = y;
    hud_bus.sprite_data = sd;
  endtask

  // Inputs held across one rising edge, then sampled 1 time unit later
  task automatic step(input logic l, input logic g, input logic r, input logic c);
    lose_life  = l;
    gain_life  = g;
    restart    = r;
    coin_pulse = c;
    @(posedge frame_clk);
    #1;
    lose_life  = 1'b0;
    gain_life  = 1'b0;
    restart    = 1'b0;
    coin_pulse = 1'b0;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'd30, 10'd20, 4'd5,  4'd3, 1'b0, 1'b0, 1'b1, 19'd0,    24'h1D7B01};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 10'd44, 10'd33, 4'd0,  4'd3, 1'b0, 1'b0, 1'b0, 19'd2458, 24'h000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 10'd45, 10'd20, 4'd7,  4'd3, 1'b0, 1'b0, 1'b0, 19'd0,    24'h000000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 10'd45, 10'd20, 4'd7,  4'd4, 1'b0, 1'b0, 1'b1, 19'd0,    24'hD4E7C7};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'd46, 10'd21, 4'd2,  4'd5, 1'b0, 1'b0, 1'b1, 19'd189,  24'hB53121};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 10'd74, 10'd20, 4'd15, 4'd5, 1'b0, 1'b0, 1'b1, 19'd14,   24'hFF0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10'd75, 10'd20, 4'd1,  4'd5, 1'b0, 1'b0, 1'b0, 19'd0,    24'h000000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 10'd0,  10'd19, 4'd1,  4'd5, 1'b0, 1'b0, 1'b0, 19'd0,    24'h000000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 10'd0,  10'd34, 4'd1,  4'd5, 1'b0, 1'b0, 1'b0, 19'd0,    24'h000000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'd14, 10'd33, 4'd9,  4'd5, 1'b0, 1'b0, 1'b1, 19'd2458, 24'h000000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 10'd1,  10'd20, 4'd3,  4'd5, 1'b0, 1'b0, 1'b1, 19'd1,    24'hF83800};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10'd16, 10'd22, 4'd4,  4'd5, 1'b0, 1'b0, 1'b1, 19'd377,  24'hE18300};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10'd17, 10'd20, 4'd6,  4'd5, 1'b0, 1'b0, 1'b1, 19'd2,    24'hAC7C00};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 10'd18, 10'd20, 4'd8,  4'd5, 1'b0, 1'b0, 1'b1, 19'd3,    24'h057987};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 10'd19, 10'd20, 4'd10, 4'd5, 1'b0, 1'b0, 1'b1, 19'd4,    24'hFF0000};

    Reset      = 1'b1;
    lose_life  = 1'b0;
    gain_life  = 1'b0;
    restart    = 1'b0;
    coin_pulse = 1'b0;
    set_pix(10'd0, 10'd0, 4'd0);
    #12;
    chk("reset_count", 32'(life_count), 32'd3);
    chk("reset_inv", 32'(invulnerable), 32'd0);
    chk("reset_over", 32'(game_over), 32'd0);
    Reset = 1'b0;

    // Blink window: slot 2 hidden for 4 frames, shown for 4, ... ; second hit ignored
    set_pix(10'd30, 10'd20, 4'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hit_count", 32'(life_count), 32'd2);
    chk("hit_inv_lag", 32'(invulnerable), 32'd0);
    chk("hit_vis0", 32'(hud_bus.is_life), 32'd0);
    for (int k = 1; k <= 60; k++) begin
      step((k == 10) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0);
      chk("blink_count", 32'(life_count), 32'd2);
      chk("blink_inv", 32'(invulnerable), 32'd1);
      chk("blink_vis", 32'(hud_bus.is_life), (k < 60) ? 32'((k / 4) % 2) : 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blink_end_inv", 32'(invulnerable), 32'd0);
    chk("blink_end_count", 32'(life_count), 32'd2);

    // Asynchronous reset in the middle of a blink window
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midhit_inv", 32'(invulnerable), 32'd1);
    chk("midhit_count", 32'(life_count), 32'd1);
    pulse_reset();
    chk("async_count", 32'(life_count), 32'd3);
    chk("async_inv", 32'(invulnerable), 32'd0);
    set_pix(10'd30, 10'd20, 4'd5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_count", 32'(life_count), 32'd3);
    chk("rst_inv", 32'(invulnerable), 32'd0);
    chk("rst_is_life", 32'(hud_bus.is_life), 32'd1);
    chk("rst_addr", 32'(hud_bus.sprite_addr), 32'd0);
    chk("rst_rgb", {8'd0, hud_bus.Red, hud_bus.Green, hud_bus.Blue}, 32'h1D7B01);

    for (int v = 0; v < 15; v++) begin
      set_pix(vecs[v].x, vecs[v].y, vecs[v].sd);
      step(vecs[v].lose, vecs[v].gain, vecs[v].rst_req, 1'b0);
      chk($sformatf("v%0d_count", v), 32'(life_count), 32'(vecs[v].cnt));
      chk($sformatf("v%0d_inv", v), 32'(invulnerable), 32'(vecs[v].inv));
      chk($sformatf("v%0d_over", v), 32'(game_over), 32'(vecs[v].ovr));
      chk($sformatf("v%0d_is_life", v), 32'(hud_bus.is_life), 32'(vecs[v].isl));
      chk($sformatf("v%0d_addr", v), 32'(hud_bus.sprite_addr), 32'(vecs[v].addr));
      chk($sformatf("v%0d_rgb", v), {8'd0, hud_bus.Red, hud_bus.Green, hud_bus.Blue},
          32'(vecs[v].rgb));
    end

    // Three spaced hits lead to game over; restart brings the count back
    pulse_reset();
    set_pix(10'd0, 10'd20, 4'd1);
    for (int h = 0; h < 3; h++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 61; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("over_flag", 32'(game_over), 32'd1);
    chk("over_count", 32'(life_count), 32'd0);
    chk("over_inv", 32'(invulnerable), 32'd0);
    chk("over_no_icon", 32'(hud_bus.is_life), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("over_gain_ignored", 32'(life_count), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("restart_count", 32'(life_count), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_over", 32'(game_over), 32'd0);
    chk("restart_icon", 32'(hud_bus.is_life), 32'd1);

    // Coin bonus
    for (int c = 0; c < 99; c++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("coin99_count", 32'(life_count), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef LIFE_HUD_BONUS_EN
    chk("coin100_count", 32'(life_count), 32'd4);
`else
    chk("coin100_count", 32'(life_count), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
